// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl
// Sequencer for the up/down counter datapath. A sweep command (peak, reps)
// is taken over a valid/ready handshake. The block then drives the counter's
// enable/direction so the counter traces 0 -> peak -> 0, (reps+1) times.
// It also keeps a mirror of the value the counter should hold.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   cmd_valid  command present
//   cmd_ready  controller can accept a command (high only in IDLE)
//   cmd_peak   sweep peak value, sampled on accept
//   cmd_reps   number of triangles minus 1, sampled on accept
//   abort      terminate the running sweep (honoured in UP/DOWN only)
//   cnt_en     to counter enable (counter clears while low)
//   cnt_down   to counter direction (1 = decrement)
//   count_q    mirror of the expected counter value
//   busy       high while in UP or DOWN
//   done       one-cycle pulse at sweep end
//   aborted    qualifies done: sweep ended by abort
//   state_dbg  current FSM state (IDLE=0, UP=1, DOWN=2, DONE=3)
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready does not depend on cmd_valid, so the
// source may hold cmd_valid with stable data until the transfer. Nothing is
// queued: cmd_valid outside IDLE has no effect.

module updown_sweep_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_peak,
    input  logic [3:0]       cmd_reps,
    input  logic             abort,
    output logic             cnt_en,
    output logic             cnt_down,
    output logic [WIDTH-1:0] count_q,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] peak_q, peak_n;
    logic [3:0]       reps_q, reps_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] count_inc, count_dec;
    logic             aborted_n;

    assign count_inc = count_q + WIDTH'(1);
    assign count_dec = count_q - WIDTH'(1);
    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        peak_n    = peak_q;
        reps_n    = reps_q;
        count_n   = count_q;
        aborted_n = 1'b0;
        case (state)
            S_IDLE: begin
                count_n = '0;
                if (cmd_valid) begin
                    peak_n = cmd_peak;
                    reps_n = cmd_reps;
                    // A zero peak never enables the counter.
                    state_n = (cmd_peak == '0) ? S_DONE : S_UP;
                end
            end
            S_UP: begin
                if (abort) begin
                    state_n   = S_DONE;
                    aborted_n = 1'b1;
                    count_n   = '0;
                end else begin
                    count_n = count_inc;
                    // Exact compare: the peak value is shown in the first
                    // DOWN cycle, so it is held for one cycle only.
                    if (count_inc == peak_q)
                        state_n = S_DOWN;
                end
            end
            S_DOWN: begin
                if (abort) begin
                    state_n   = S_DONE;
                    aborted_n = 1'b1;
                    count_n   = '0;
                end else begin
                    count_n = count_dec;
                    if (count_dec == '0) begin
                        if (reps_q != 4'd0) begin
                            reps_n  = reps_q - 4'd1;
                            state_n = S_UP;
                        end else begin
                            state_n = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                count_n = '0;
                state_n = S_IDLE;
            end
            default: begin
                count_n = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            peak_q    <= '0;
            reps_q    <= '0;
            count_q   <= '0;
            cmd_ready <= 1'b1;
            cnt_en    <= 1'b0;
            cnt_down  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            peak_q    <= peak_n;
            reps_q    <= reps_n;
            count_q   <= count_n;
            cmd_ready <= (state_n == S_IDLE);
            cnt_en    <= (state_n == S_UP) || (state_n == S_DOWN);
            cnt_down  <= (state_n == S_DOWN);
            busy      <= (state_n == S_UP) || (state_n == S_DOWN);
            done      <= (state_n == S_DONE);
            aborted   <= aborted_n;
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl. The reference model turns each accepted
// command into the full list of per-cycle outputs it must produce. A
// separate behavioural counter driven by the DUT's cnt_en/cnt_down
// stands in for the real datapath counter.

module tb_updown_sweep_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_peak;
    logic [3:0] cmd_reps;
    logic       abort;
    logic       cnt_en;
    logic       cnt_down;
    logic [7:0] count_q;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [1:0] state_dbg;

    updown_sweep_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_peak  (cmd_peak),
        .cmd_reps  (cmd_reps),
        .abort     (abort),
        .cnt_en    (cnt_en),
        .cnt_down  (cnt_down),
        .count_q   (count_q),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model / scoreboard ----------------
    typedef struct packed {
        logic       en;
        logic       dn;
        logic [7:0] cnt;
        logic       dpulse;
        logic       ab;
    } exp_t;

    exp_t exp_q[$];          // outputs expected for the current and future cycles
    int   checks;
    int   errors;
    int   ctr;               // behavioural counter value
    logic prev_en, prev_dn;  // counter controls seen before the edge
    int   tr_cnt[$];         // count_q on enabled cycles of the current run
    int   tr_dn[$];          // cnt_down on enabled cycles of the current run

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build(input int pk, input int rp);
        if (pk == 0) begin
            exp_q.push_back('{en: 1'b0, dn: 1'b0, cnt: 8'd0, dpulse: 1'b1, ab: 1'b0});
        end else begin
            for (int r = 0; r <= rp; r++) begin
                for (int i = 0; i < pk; i++)
                    exp_q.push_back('{en: 1'b1, dn: 1'b0, cnt: 8'(i), dpulse: 1'b0, ab: 1'b0});
                for (int i = pk; i >= 1; i--)
                    exp_q.push_back('{en: 1'b1, dn: 1'b1, cnt: 8'(i), dpulse: 1'b0, ab: 1'b0});
            end
            exp_q.push_back('{en: 1'b0, dn: 1'b0, cnt: 8'd0, dpulse: 1'b1, ab: 1'b0});
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ctr     = 0;
        prev_en = 1'b0;
        prev_dn = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs in force.
    task automatic model_edge();
        exp_t cur;
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            if (cur.en && abort) begin
                exp_q.delete();
                exp_q.push_back('{en: 1'b0, dn: 1'b0, cnt: 8'd0, dpulse: 1'b1, ab: 1'b1});
            end
        end else if (cmd_valid) begin
            build(int'(cmd_peak), int'(cmd_reps));
        end
        if (!prev_en)      ctr = 0;
        else if (prev_dn)  ctr = (ctr + 255) % 256;
        else               ctr = (ctr + 1) % 256;
    endtask

    task automatic compare();
        exp_t e;
        e = '0;
        if (exp_q.size() != 0) e = exp_q[0];
        check("cmd_ready", cmd_ready, (exp_q.size() == 0));
        check("cnt_en",    cnt_en,    e.en);
        check("cnt_down",  cnt_down,  e.dn);
        check("count_q",   count_q,   e.cnt);
        check("busy",      busy,      e.en);
        check("done",      done,      e.dpulse);
        check("aborted",   aborted,   e.ab);
        if (cnt_en) begin
            check("mirror_vs_counter", count_q, ctr);
            tr_cnt.push_back(int'(count_q));
            tr_dn.push_back(int'(cnt_down));
        end
        prev_en = cnt_en;
        prev_dn = cnt_down;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("wait_ready", cmd_ready, 1);
    endtask

    task automatic start_cmd(input int pk, input int rp);
        wait_ready();
        tr_cnt.delete();
        tr_dn.delete();
        cmd_valid = 1'b1;
        cmd_peak  = 8'(pk);
        cmd_reps  = 4'(rp);
        step();
        cmd_valid = 1'b0;
    endtask

    // lat = cycles from the accept edge to the DONE cycle.
    task automatic run_cmd(input int pk, input int rp, input bit noisy,
                           output int lat, output bit was_aborted);
        start_cmd(pk, rp);
        lat = 1;
        while (!done && lat < 9000) begin
            if (noisy) begin
                cmd_valid = ($urandom_range(0, 3) == 0);
                cmd_peak  = 8'($urandom_range(0, 255));
                cmd_reps  = 4'($urandom_range(0, 15));
                abort     = ($urandom_range(0, 63) == 0);
            end
            step();
            lat++;
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        check("done_seen", done, 1);
        was_aborted = aborted;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        bit ab;
        int n;
        checks    = 0;
        errors    = 0;
        cmd_valid = 1'b0;
        cmd_peak  = 8'd0;
        cmd_reps  = 4'd0;
        abort     = 1'b0;
        model_reset();

        // Reset state
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cnt_en",    cnt_en,    0);
        check("rst_cnt_down",  cnt_down,  0);
        check("rst_count_q",   count_q,   0);
        check("rst_busy",      busy,      0);
        check("rst_done",      done,      0);
        check("rst_aborted",   aborted,   0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        step();

        // Peak 3, one triangle
        run_cmd(3, 0, 1'b0, lat, ab);
        check("p3_lat", lat, 7);
        check("p3_len", tr_cnt.size(), 6);
        if (tr_cnt.size() == 6) begin
            int exp_c[6] = '{0, 1, 2, 3, 2, 1};
            int exp_d[6] = '{0, 0, 0, 1, 1, 1};
            for (int i = 0; i < 6; i++) begin
                check("p3_seq", tr_cnt[i], exp_c[i]);
                check("p3_dir", tr_dn[i], exp_d[i]);
            end
        end
        check("p3_done_cnt", count_q, 0);
        check("p3_not_aborted", ab, 0);

        // Peak 2, two triangles
        run_cmd(2, 1, 1'b0, lat, ab);
        check("p2r1_len", tr_cnt.size(), 8);
        if (tr_cnt.size() == 8) begin
            int exp_c[8] = '{0, 1, 2, 1, 0, 1, 2, 1};
            int exp_d[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
            for (int i = 0; i < 8; i++) begin
                check("p2r1_seq", tr_cnt[i], exp_c[i]);
                check("p2r1_dir", tr_dn[i], exp_d[i]);
            end
        end

        // Peak 0: DONE at T0+1, ready at T0+2, counter never enabled
        run_cmd(0, 5, 1'b0, lat, ab);
        check("p0_lat", lat, 1);
        check("p0_no_enable", tr_cnt.size(), 0);
        step();
        check("p0_ready_t2", cmd_ready, 1);

        // Peak 255: full range, no wrap
        run_cmd(255, 0, 1'b0, lat, ab);
        check("p255_len", tr_cnt.size(), 510);
        check("p255_lat", lat, 511);
        if (tr_cnt.size() == 510) begin
            check("p255_top", tr_cnt[255], 255);
            check("p255_last", tr_cnt[509], 1);
        end

        // Abort at count 5 in UP; a new command during the run is ignored
        start_cmd(10, 0);
        n = 0;
        while (count_q != 8'd5 && n < 20) begin
            step();
            n++;
        end
        check("abort_reach5", count_q, 5);
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_peak  = 8'd7;
        step();
        abort     = 1'b0;
        check("abort_done",    done,    1);
        check("abort_aborted", aborted, 1);
        check("abort_cnt_en",  cnt_en,  0);
        step();
        cmd_valid = 1'b0;
        check("abort_ready", cmd_ready, 1);
        check("abort_no_accept", cnt_en, 0);
        step();

        // Reset in the middle of DOWN
        start_cmd(6, 2);
        n = 0;
        while (!cnt_down && n < 20) begin
            step();
            n++;
        end
        step();
        check("rst_mid_in_down", cnt_down, 1);
        #2 reset = 1'b0;
        #1;
        check("rstm_cmd_ready", cmd_ready, 1);
        check("rstm_cnt_en",    cnt_en,    0);
        check("rstm_cnt_down",  cnt_down,  0);
        check("rstm_count_q",   count_q,   0);
        check("rstm_busy",      busy,      0);
        check("rstm_done",      done,      0);
        check("rstm_aborted",   aborted,   0);
        model_reset();
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        repeat (3) step();
        run_cmd(4, 0, 1'b0, lat, ab);
        check("post_rst_len", tr_cnt.size(), 8);
        check("post_rst_lat", lat, 9);

        // Randomised sweeps with noise commands and occasional aborts
        for (int k = 0; k < 24; k++) begin
            int pk, rp;
            pk = (k % 8 == 0) ? 1 : $urandom_range(0, 40);
            rp = $urandom_range(0, 3);
            run_cmd(pk, rp, 1'b1, lat, ab);
            if (!ab) begin
                check("rand_lat", lat, (pk == 0) ? 1 : 2 * pk * (rp + 1) + 1);
                check("rand_len", tr_cnt.size(), 2 * pk * (rp + 1));
            end
        end
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_sweep_ctrl.md
# updown_sweep_ctrl

Sequencer for the 8-bit up/down counter datapath. It accepts a sweep command (peak value, repetition count) over a valid/ready handshake. It then drives the counter's enable and direction inputs to produce a triangle sequence 0 → peak → 0, repeated N times, and keeps an internal mirror of the expected count. It sits between the test/control logic and the counter instance and is the only driver of the counter's `enable` and `modo_UpDown` inputs.

## Interface
- `WIDTH`, default 8: count/peak width; must match the counter width.
- `clk  in  1`: clock, rising-edge.
- `reset  in  1`: asynchronous, active-low.
- `cmd_valid  in  1`: command present.
- `cmd_ready  out  1`: controller can accept a command. High only in IDLE.
- `cmd_peak  in  WIDTH`: sweep peak value, sampled on accept.
- `cmd_reps  in  4`: number of triangles minus 1 (0 → 1 triangle, 15 → 16 triangles), sampled on accept.
- `abort  in  1`: terminate the running sweep.
- `cnt_en  out  1`: to counter `enable`.
- `cnt_down  out  1`: to counter `modo_UpDown` (1 = decrement).
- `count_q  out  WIDTH`: mirror of the expected counter value.
- `busy  out  1`: high in UP and DOWN.
- `done  out  1`: one-cycle pulse at sweep end.
- `aborted  out  1`: qualifies `done`; high when the sweep ended by `abort`.

## Operation
- All outputs are registered.
- Reset values: state = IDLE, `cmd_ready` = 1, `cnt_en` = 0, `cnt_down` = 0, `count_q` = 0, `busy` = 0, `done` = 0, `aborted` = 0, internal peak/reps = 0.
- States:
  - IDLE: `cnt_en` = 0. The counter clears whenever enable is low, so `count_q` is held at 0.
  - UP: `cnt_en` = 1, `cnt_down` = 0.
  - DOWN: `cnt_en` = 1, `cnt_down` = 1.
  - DONE: `cnt_en` = 0, `count_q` ← 0.
- IDLE: when `cmd_valid` and `cmd_ready` are both high, latch peak and reps.
  - If `cmd_peak` = 0, go to DONE. The counter is never enabled.
  - Otherwise go to UP with `count_q` = 0.
- UP: `count_q` ← `count_q` + 1 each cycle. When the next value equals peak, go to DOWN.
- DOWN: `count_q` ← `count_q` − 1 each cycle. When the next value equals 0:
  - if remaining reps > 0, decrement reps and go to UP;
  - otherwise go to DONE.
- DONE: lasts exactly one cycle, with `done` = 1 during it, then returns to IDLE.
- `abort` sampled high in UP or DOWN: go to DONE on the next edge with `aborted` = 1. `abort` is ignored in IDLE and DONE.
- Arithmetic:
  - `count_q` never wraps: it stays within 0..peak because the turn-around compares are exact.
  - Peak = 2^WIDTH−1 is legal.
- `cmd_valid` while not in IDLE is ignored (`cmd_ready` = 0). No command is queued.

## Timing
- Accept edge T0. First UP cycle is T0+1, with `count_q` = 0 and `cnt_en` = 1.
- Enabled cycles per sweep = 2 × peak × (reps+1). DONE follows immediately. `cmd_ready` returns the cycle after DONE.
- On every enabled cycle, `count_q` equals the counter output, because both update on the same edge from the same controls.
- Direction reversals are single-cycle:
  - the peak value is held for exactly one cycle;
  - the intermediate 0 between triangles is held for one cycle.
- `done` and `aborted` are high only during the DONE cycle.
- Reset mid-operation: every output returns to its reset value immediately (asynchronous). The latched command is discarded and no `done` is produced.
- Peak-0 command: accept at T0, DONE at T0+1, IDLE at T0+2.

## Test plan
- Peak = 3, reps = 0 → `count_q`/counter over UP/DOWN cycles: 0,1,2,3,2,1. DONE follows with value 0. 6 enabled cycles, `done` = 1, `aborted` = 0.
- Peak = 2, reps = 1 → 0,1,2,1,0,1,2,1, then DONE. 8 enabled cycles. `cnt_down` is high exactly on cycles showing 2,1 of each triangle.
- Peak = 0 → `cnt_en` never asserted. `done` pulses at T0+1 and `cmd_ready` is 1 again at T0+2.
- Peak = 255, reps = 0 → counter reaches 255 with no wrap, returns to 0 after 510 enabled cycles, and mirror equals counter every cycle.
- Peak = 10, `abort` pulsed when `count_q` = 5 in UP → next cycle DONE with `cnt_en` = 0, `done` = 1, `aborted` = 1. A new `cmd_valid` during the run is not accepted.
- `reset` asserted mid-DOWN → all outputs are 0 and `cmd_ready` = 1 without waiting for a clock edge. No `done` pulse occurs. A fresh command after release runs normally.
